ksa_pipe_adder: RTL and testbench

Parametrised, fully pipelined Kogge-Stone adder/subtractor with a valid/ready handshake. It is the clocked successor to the 16-bit combinational Kogge-Stone adder. It generalises operand width and adds a subtract mode, a signed-overflow flag and backpressure. One operation is accepted per cycle, and results emerge in order after a fixed latency.

---
 rtl/ksa_pipe_adder.sv | 96 +++++++++
 tb/tb_ksa_pipe_adder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ksa_pipe_adder.sv
// Pipelined Kogge-Stone adder/subtractor, LOG2W+2 register stages, in-order results.
// Global stall: when out_valid && !out_ready every stage holds and in_ready drops.
module ksa_pipe_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int LOG2W = $clog2(WIDTH);

  // Bit 0 of every (G,P) vector is a virtual bit carrying c0; real bit b sits at b+1.
  logic [WIDTH:0]   r_g  [0:LOG2W];
  logic [WIDTH:0]   r_p  [0:LOG2W];
  logic [WIDTH-1:0] r_hp [0:LOG2W];
  logic [LOG2W:0]   r_v;
  logic             r_out_vld;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_stall;
  logic [WIDTH-1:0] w_y;
  logic [WIDTH:0]   w_g [1:LOG2W];
  logic [WIDTH:0]   w_p [1:LOG2W];
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;

  assign w_stall  = r_out_vld & ~out_ready;
  assign in_ready = ~w_stall;
  assign w_y      = in_sub ? ~in_y : in_y;

  genvar lv;
  generate
    for (lv = 1; lv <= LOG2W; lv++) begin : g_lvl
      localparam int D = 2 ** (lv - 1);
      localparam logic [WIDTH:0] LOMASK = {(WIDTH + 1){1'b1}} >> (WIDTH + 1 - D);
      assign w_g[lv] = r_g[lv-1] | (r_p[lv-1] & (r_g[lv-1] << D));
      assign w_p[lv] = r_p[lv-1] & ((r_p[lv-1] << D) | LOMASK);
    end
  endgenerate

  // After LOG2W levels every group except the top one already reaches the virtual bit.
  assign w_cout = r_g[LOG2W][WIDTH] | (r_p[LOG2W][WIDTH] & r_g[LOG2W][0]);
  assign w_sum  = r_hp[LOG2W] ^ r_g[LOG2W][WIDTH-1:0];
  assign w_ovf  = r_g[LOG2W][WIDTH-1] ^ w_cout;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= LOG2W; i++) begin
        r_g[i]  <= '0;
        r_p[i]  <= '0;
        r_hp[i] <= '0;
      end
      r_v       <= '0;
      r_out_vld <= 1'b0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (!w_stall) begin
      r_g[0]  <= {in_x & w_y, in_sub | in_cin};
      r_p[0]  <= {in_x ^ w_y, 1'b0};
      r_hp[0] <= in_x ^ w_y;
      for (int i = 1; i <= LOG2W; i++) begin
        r_g[i]  <= w_g[i];
        r_p[i]  <= w_p[i];
        r_hp[i] <= r_hp[i-1];
      end
      r_v       <= {r_v[LOG2W-1:0], in_valid};
      r_out_vld <= r_v[LOG2W];
      if (r_v[LOG2W]) begin
        r_sum  <= w_sum;
        r_cout <= w_cout;
        r_ovf  <= w_ovf;
      end
    end
  end

  assign out_valid = r_out_vld;
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;
  assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_ksa_pipe_adder.sv
// Scoreboard bench for ksa_pipe_adder at WIDTH 8/16/32/64; all instances share stimulus,
// cw selects which one is observed. Latency counts rising edges, the accepting edge being 1.
module tb_ksa_pipe_adder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [63:0] in_x = '0;
  logic [63:0] in_y = '0;
  logic        in_cin = 1'b0;
  logic        in_sub = 1'b0;
  logic        out_ready = 1'b1;

  logic rdy8, vld8, cout8, ovf8;     logic [7:0]  sum8;
  logic rdy16, vld16, cout16, ovf16; logic [15:0] sum16;
  logic rdy32, vld32, cout32, ovf32; logic [31:0] sum32;
  logic rdy64, vld64, cout64, ovf64; logic [63:0] sum64;

  ksa_pipe_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy8),
    .in_x(in_x[7:0]), .in_y(in_y[7:0]), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(vld8), .out_ready(out_ready), .out_sum(sum8), .out_cout(cout8), .out_ovf(ovf8));
  ksa_pipe_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy16),
    .in_x(in_x[15:0]), .in_y(in_y[15:0]), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(vld16), .out_ready(out_ready), .out_sum(sum16), .out_cout(cout16), .out_ovf(ovf16));
  ksa_pipe_adder #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32),
    .in_x(in_x[31:0]), .in_y(in_y[31:0]), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(vld32), .out_ready(out_ready), .out_sum(sum32), .out_cout(cout32), .out_ovf(ovf32));
  ksa_pipe_adder #(.WIDTH(64)) u_dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy64),
    .in_x(in_x), .in_y(in_y), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(vld64), .out_ready(out_ready), .out_sum(sum64), .out_cout(cout64), .out_ovf(ovf64));

  always #5 clk = ~clk;

  int          cw = 16;
  logic        obs_rdy, obs_vld, obs_cout, obs_ovf;
  logic [63:0] obs_sum;

  always_comb begin
    obs_rdy = rdy16; obs_vld = vld16; obs_sum = 64'(sum16); obs_cout = cout16; obs_ovf = ovf16;
    case (cw)
      8:  begin obs_rdy = rdy8;  obs_vld = vld8;  obs_sum = 64'(sum8);  obs_cout = cout8;  obs_ovf = ovf8;  end
      32: begin obs_rdy = rdy32; obs_vld = vld32; obs_sum = 64'(sum32); obs_cout = cout32; obs_ovf = ovf32; end
      64: begin obs_rdy = rdy64; obs_vld = vld64; obs_sum = sum64;      obs_cout = cout64; obs_ovf = ovf64; end
      default: ;
    endcase
  end

  int          n_chk = 0;
  int          n_fail = 0;
  int          n_res = 0;
  logic [65:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [66:0] prev_out = '0;

  function automatic logic [63:0] mask_of(input int w);
    return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  // Reference: plain wide addition; overflow from operand/result sign bits.
  function automatic logic [65:0] model(input int w, input logic [63:0] x, y, input logic cin, sub);
    logic [63:0] m, xm, yy, s, t, xs, ys, ss;
    logic [64:0] full;
    logic        ovf;
    m    = mask_of(w);
    xm   = x & m;
    yy   = (sub ? ~y : y) & m;
    full = {1'b0, xm} + {1'b0, yy} + {64'd0, sub | cin};
    s    = full[63:0] & m;
    t    = 64'(full >> w);
    xs   = xm >> (w - 1);
    ys   = yy >> (w - 1);
    ss   = s >> (w - 1);
    ovf  = (xs[0] == ys[0]) && (ss[0] != xs[0]);
    return {ovf, t[0], s};
  endfunction

  // One clock cycle of stimulus plus scoreboard/handshake monitoring; called at a negedge.
  task automatic step(input logic v, input logic [63:0] x, y, input logic c, s,
                      input logic ordy, output logic acc);
    logic [65:0] e;
    in_valid = v; in_x = x & mask_of(cw); in_y = y & mask_of(cw);
    in_cin = c; in_sub = s; out_ready = ordy;
    #1;
    n_chk++;
    if (obs_rdy !== !(obs_vld && !ordy)) begin
      n_fail++;
      $display("FAIL in_ready w=%0d: got %b, want %b", cw, obs_rdy, !(obs_vld && !ordy));
    end
    if (prev_stall) begin
      n_chk++;
      if ({obs_vld, obs_ovf, obs_cout, obs_sum} !== prev_out) begin
        n_fail++;
        $display("FAIL stall_hold w=%0d: got %h, want %h", cw,
                 {obs_vld, obs_ovf, obs_cout, obs_sum}, prev_out);
      end
    end
    if (obs_vld && ordy) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result w=%0d: got sum=%h, want no result", cw, obs_sum);
      end else begin
        e = exp_q.pop_front();
        n_res++;
        if ({obs_ovf, obs_cout, obs_sum} !== e) begin
          n_fail++;
          $display("FAIL result w=%0d: got ovf=%b cout=%b sum=%h, want ovf=%b cout=%b sum=%h",
                   cw, obs_ovf, obs_cout, obs_sum, e[65], e[64], e[63:0]);
        end
      end
    end
    prev_stall = obs_vld && !ordy;
    prev_out   = {obs_vld, obs_ovf, obs_cout, obs_sum};
    acc = v && obs_rdy;
    if (acc) exp_q.push_back(model(cw, x, y, c, s));
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    prev_stall = 1'b0;
  endtask

  task automatic drain(input bit bp);
    logic acc;
    for (int k = 0; k < 400 && exp_q.size() > 0; k++)
      step(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, bp ? (k % 3 == 0) : 1'b1, acc);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout w=%0d: got %0d pending, want 0", cw, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_x = 64'h5; in_y = 64'h7; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    exp_q.delete(); prev_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cw = 8 << i;
      #1;
      n_chk++;
      if ({obs_vld, obs_sum, obs_cout, obs_ovf, obs_rdy} !== {1'b0, 64'd0, 1'b0, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL reset_values w=%0d: got vld=%b sum=%h cout=%b ovf=%b rdy=%b, want 0/0/0/0/1",
                 cw, obs_vld, obs_sum, obs_cout, obs_ovf, obs_rdy);
      end
    end
    cw = 64;
    @(negedge clk);
    begin
      logic acc;
      repeat (10) step(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, acc);
    end
  endtask

  task automatic test_single(input int w, input logic [63:0] x, y, input logic c, s,
                             input int exp_lat, input logic [63:0] e_sum,
                             input logic e_cout, e_ovf, input bit rst);
    int lat;
    bit got;
    cw = w;
    if (rst) do_reset();
    in_valid = 1'b1; in_x = x; in_y = y; in_cin = c; in_sub = s; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1; got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (obs_vld) got = 1; else lat++;
    end
    n_chk++;
    if (!got || lat != exp_lat) begin
      n_fail++;
      $display("FAIL latency w=%0d: got %0d (seen=%0d), want %0d", w, lat, got, exp_lat);
    end
    n_chk++;
    if ({obs_sum, obs_cout, obs_ovf} !== {e_sum, e_cout, e_ovf}) begin
      n_fail++;
      $display("FAIL single w=%0d: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
               w, obs_sum, obs_cout, obs_ovf, e_sum, e_cout, e_ovf);
    end
    @(negedge clk);
    n_chk++;
    if (obs_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL one_cycle_valid w=%0d: got %b, want 0", w, obs_vld);
    end
  endtask

  task automatic test_sweep();
    logic acc;
    int   base;
    cw = 16; do_reset();
    base = n_res;
    for (int xi = 0; xi < 66; xi++)
      for (int yi = 0; yi < 66; yi++)
        step(1'b1, 64'(xi * 1000), 64'(yi * 1000), 1'((xi + yi) & 1), 1'b0, 1'b1, acc);
    drain(0);
    n_chk++;
    if (n_res - base != 4356) begin
      n_fail++;
      $display("FAIL sweep_count: got %0d, want 4356", n_res - base);
    end
  endtask

  task automatic test_backpressure();
    logic acc;
    int   accepted, cyc, base;
    cw = 16; do_reset();
    base = n_res; accepted = 0; cyc = 0;
    while (accepted < 10 && cyc < 200) begin
      step(1'b1, 64'(16'h1357 * accepted + 9), 64'(16'h2468 * accepted + 3),
           1'(accepted & 1), 1'(accepted % 3 == 2), 1'(cyc % 3 == 0), acc);
      if (acc) accepted++;
      cyc++;
    end
    drain(1);
    n_chk++;
    if (accepted != 10 || n_res - base != 10) begin
      n_fail++;
      $display("FAIL backpressure_count: got acc=%0d res=%0d, want 10/10", accepted, n_res - base);
    end
  endtask

  task automatic test_reset_midstream();
    logic acc;
    int   base;
    cw = 16; do_reset();
    for (int i = 0; i < 4; i++)
      step(1'b1, 64'(100 + i), 64'(200 + i), 1'b0, 1'b0, 1'b1, acc);
    reset = 1'b1; in_valid = 1'b1; in_x = 64'h1111; in_y = 64'h2222;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    exp_q.delete(); prev_stall = 1'b0;
    #1;
    n_chk++;
    if ({obs_vld, obs_sum, obs_cout, obs_ovf, obs_rdy} !== {1'b0, 64'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL midreset_values: got vld=%b sum=%h cout=%b ovf=%b rdy=%b, want 0/0/0/0/1",
               obs_vld, obs_sum, obs_cout, obs_ovf, obs_rdy);
    end
    base = n_res;
    @(negedge clk);
    repeat (12) step(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, acc);
    n_chk++;
    if (n_res != base) begin
      n_fail++;
      $display("FAIL midreset_leak: got %0d results, want 0", n_res - base);
    end
    test_single(16, 64'h0F0F, 64'h00F1, 1'b1, 1'b0, 6, 64'h1001, 1'b0, 1'b0, 0);
  endtask

  task automatic test_random64();
    logic acc;
    int   accepted, base;
    cw = 64; do_reset();
    base = n_res; accepted = 0;
    for (int k = 0; k < 6000 && accepted < 1000; k++) begin
      step(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, {$urandom, $urandom},
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
      if (acc) accepted++;
    end
    drain(0);
    n_chk++;
    if (accepted != 1000 || n_res - base != 1000) begin
      n_fail++;
      $display("FAIL random64_count: got acc=%0d res=%0d, want 1000/1000", accepted, n_res - base);
    end
  endtask

  initial begin
    test_reset();
    test_single(16, 64'hFFFF, 64'h0001, 1'b0, 1'b0, 6, 64'h0000, 1'b1, 1'b0, 1);
    test_single(16, 64'h8000, 64'h0001, 1'b0, 1'b1, 6, 64'h7FFF, 1'b1, 1'b1, 1);
    test_single(16, 64'h0003, 64'h0005, 1'b0, 1'b1, 6, 64'hFFFE, 1'b0, 1'b0, 1);
    test_sweep();
    test_backpressure();
    test_reset_midstream();
    test_single(8, 64'hFF, 64'h01, 1'b1, 1'b0, 5, 64'h01, 1'b1, 1'b0, 1);
    test_single(32, 64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0, 7, 64'h8000_0000, 1'b0, 1'b1, 1);
    test_single(64, 64'h0, 64'h1, 1'b0, 1'b1, 8, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1);
    test_random64();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
